// File: rtl/mst_fifo_ctl_if.sv
// rtl/mst_fifo_ctl_if.sv - FT60x master FIFO pad-side and stream-side signal bundle
interface mst_fifo_ctl_if #(
    parameter int DW  = 16,
    parameter int BEW = DW / 8
);
    logic           txe_n;
    logic           rxf_n;
    logic [DW-1:0]  idata;
    logic [BEW-1:0] ibe;
    logic [DW-1:0]  odata;
    logic [BEW-1:0] obe;
    logic           dt_oe_n;
    logic           be_oe_n;
    logic           wr_n;
    logic           rd_n;
    logic           oe_n;
    logic           tx_vld;
    logic           tx_rdy;
    logic [DW-1:0]  tx_dat;
    logic [BEW-1:0] tx_be;
    logic           rx_vld;
    logic [DW-1:0]  rx_dat;
    logic [BEW-1:0] rx_be;
    logic           rx_afull;
    logic [31:0]    wr_cnt;
    logic [31:0]    rd_cnt;

    modport master (
        input  txe_n, rxf_n, idata, ibe, tx_vld, tx_dat, tx_be, rx_afull,
        output odata, obe, dt_oe_n, be_oe_n, wr_n, rd_n, oe_n,
               tx_rdy, rx_vld, rx_dat, rx_be, wr_cnt, rd_cnt
    );

    modport slave (
        output txe_n, rxf_n, idata, ibe, tx_vld, tx_dat, tx_be, rx_afull,
        input  odata, obe, dt_oe_n, be_oe_n, wr_n, rd_n, oe_n,
               tx_rdy, rx_vld, rx_dat, rx_be, wr_cnt, rd_cnt
    );
endinterface

// File: rtl/mst_fifo_ctl.sv
// rtl/mst_fifo_ctl.sv - FT60x master FIFO bus controller with fair R/W arbitration
// Transfer counters are built only when MST_FIFO_CNT_EN is defined.
module mst_fifo_ctl #(
    parameter int DW       = 16,
    parameter int BEW      = DW / 8,
    parameter int MAXBURST = 256
) (
    input  logic           clk,
    input  logic           rst,
    mst_fifo_ctl_if.master bus
);
    localparam int             BCW   = $clog2(MAXBURST + 1);
    localparam logic [BCW-1:0] MAXB  = BCW'(MAXBURST);
    localparam logic [BCW-1:0] LASTB = BCW'(MAXBURST - 1);

    typedef enum logic [2:0] {IDLE, WR, RD_TA, RD, GAP} state_t;

    state_t         state, state_nxt;
    logic [BCW-1:0] bcnt;
    logic           last_rd, cur_rd, cur_rd_nxt;
    logic           rd_req, wr_req, wr_go, rd_go;
    logic           wr_xfer, rd_cap;

    logic           wr_n, rd_n, oe_n, dt_oe_n, be_oe_n, tx_rdy;
    logic [DW-1:0]  odata;
    logic [BEW-1:0] obe;
    logic           rx_vld;
    logic [DW-1:0]  rx_dat;
    logic [BEW-1:0] rx_be;

    assign rd_req = !bus.rxf_n && !bus.rx_afull;
    assign wr_req = !bus.txe_n && bus.tx_vld;
    assign wr_go  = wr_req && (bcnt < MAXB);
    assign rd_go  = rd_req && (bcnt < MAXB);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cur_rd_nxt = cur_rd;
        wr_n       = 1'b1;
        rd_n       = 1'b1;
        oe_n       = 1'b1;
        dt_oe_n    = 1'b1;
        be_oe_n    = 1'b1;
        odata      = '0;
        obe        = '0;
        tx_rdy     = 1'b0;
        wr_xfer    = 1'b0;
        rd_cap     = 1'b0;
        case (state)
            IDLE: begin
                // On a conflict the direction not served last wins.
                if (rd_req && (!wr_req || !last_rd)) begin
                    state_nxt  = RD_TA;
                    cur_rd_nxt = 1'b1;
                end else if (wr_req) begin
                    state_nxt  = WR;
                    cur_rd_nxt = 1'b0;
                end
            end
            WR: begin
                dt_oe_n = 1'b0;
                be_oe_n = 1'b0;
                odata   = bus.tx_dat;
                obe     = bus.tx_be;
                wr_n    = !wr_go;
                tx_rdy  = wr_go;
                wr_xfer = wr_go;
                if (!wr_go || bcnt == LASTB) state_nxt = GAP;
            end
            RD_TA: begin
                // Pads already released; the device gets one cycle to drive before rd_n.
                oe_n      = 1'b0;
                state_nxt = RD;
            end
            RD: begin
                oe_n   = 1'b0;
                rd_n   = !rd_go;
                rd_cap = rd_go;
                if (!rd_go || bcnt == LASTB) state_nxt = GAP;
            end
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt    <= '0;
            last_rd <= 1'b0;
            cur_rd  <= 1'b0;
            rx_vld  <= 1'b0;
            rx_dat  <= '0;
            rx_be   <= '0;
        end else begin
            cur_rd <= cur_rd_nxt;
            if (state == GAP) begin
                bcnt    <= '0;
                last_rd <= cur_rd;
            end else if (wr_xfer || rd_cap) begin
                bcnt <= bcnt + BCW'(1);
            end
            rx_vld <= rd_cap;
            if (rd_cap) begin
                rx_dat <= bus.idata;
                rx_be  <= bus.ibe;
            end
        end
    end

`ifdef MST_FIFO_CNT_EN
    logic [31:0] wr_cnt_q, rd_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            if (wr_xfer) wr_cnt_q <= wr_cnt_q + 32'd1;
            if (rd_cap)  rd_cnt_q <= rd_cnt_q + 32'd1;
        end
    end

    assign bus.wr_cnt = wr_cnt_q;
    assign bus.rd_cnt = rd_cnt_q;
`else
    assign bus.wr_cnt = '0;
    assign bus.rd_cnt = '0;
`endif

    assign bus.wr_n    = wr_n;
    assign bus.rd_n    = rd_n;
    assign bus.oe_n    = oe_n;
    assign bus.dt_oe_n = dt_oe_n;
    assign bus.be_oe_n = be_oe_n;
    assign bus.odata   = odata;
    assign bus.obe     = obe;
    assign bus.tx_rdy  = tx_rdy;
    assign bus.rx_vld  = rx_vld;
    assign bus.rx_dat  = rx_dat;
    assign bus.rx_be   = rx_be;
endmodule

// File: tb/tb_mst_fifo_ctl.sv
// tb/tb_mst_fifo_ctl.sv - directed bench for mst_fifo_ctl, DW=32, MAXBURST=4
module tb_mst_fifo_ctl;
`ifdef MST_FIFO_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    mst_fifo_ctl_if #(.DW(32)) bus ();

    mst_fifo_ctl #(.DW(32), .MAXBURST(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.txe_n    = 1'b1;
        bus.rxf_n    = 1'b1;
        bus.tx_vld   = 1'b0;
        bus.rx_afull = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.idata  = '0;
        bus.ibe    = '0;
        bus.tx_dat = '0;
        bus.tx_be  = '0;
        rst = 1'b1;
        step(); step(); step();
        #1;
        n_tests++;
        if ({bus.wr_n, bus.rd_n, bus.oe_n, bus.dt_oe_n, bus.be_oe_n} !== 5'b11111) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b expected 11111",
                     {bus.wr_n, bus.rd_n, bus.oe_n, bus.dt_oe_n, bus.be_oe_n});
        end
        n_tests++;
        if ({bus.odata, bus.obe, bus.tx_rdy} !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_tx_side: odata %h obe %h tx_rdy %b expected all 0",
                     bus.odata, bus.obe, bus.tx_rdy);
        end
        n_tests++;
        if ({bus.rx_vld, bus.rx_dat, bus.rx_be} !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_rx_side: rx_vld %b rx_dat %h rx_be %h expected all 0",
                     bus.rx_vld, bus.rx_dat, bus.rx_be);
        end
        n_tests++;
        if ({bus.wr_cnt, bus.rd_cnt} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_counters: wr_cnt %0d rd_cnt %0d expected 0 0", bus.wr_cnt, bus.rd_cnt);
        end
        rst = 1'b0;
        step(); step();
    endtask

    task automatic test_write_burst();
        logic [31:0] got[6];
        logic [15:0] low_vec;
        int          k;
        logic        xfer;
        k = 0;
        low_vec = '0;
        for (int c = 0; c < 16 && k < 6; c++) begin
            bus.txe_n  = 1'b0;
            bus.tx_vld = 1'b1;
            bus.tx_dat = 32'h11 + k;
            bus.tx_be  = 4'hF;
            #1;
            xfer = !bus.wr_n;
            if (xfer) begin
                got[k]     = bus.odata;
                low_vec[c] = 1'b1;
            end
            if (c == 1) begin
                n_tests++;
                if ({bus.dt_oe_n, bus.be_oe_n, bus.obe, bus.tx_rdy} !== 7'b00_1111_1) begin
                    n_fail++;
                    $display("FAIL wr_pads: dt_oe_n %b be_oe_n %b obe %h tx_rdy %b expected 0 0 f 1",
                             bus.dt_oe_n, bus.be_oe_n, bus.obe, bus.tx_rdy);
                end
            end
            step();
            if (xfer) k++;
        end
        idle_inputs();
        n_tests++;
        if (low_vec !== 16'h019E) begin
            n_fail++;
            $display("FAIL wr_burst_shape: wr_n low cycles %h expected 019e", low_vec);
        end
        n_tests++;
        if (k != 6 || got[0] !== 32'h11 || got[3] !== 32'h14 || got[4] !== 32'h15 || got[5] !== 32'h16) begin
            n_fail++;
            $display("FAIL wr_words: count %0d words %h %h %h %h expected 6 11 14 15 16",
                     k, got[0], got[3], got[4], got[5]);
        end
        step(); step(); step();
        n_tests++;
        if (bus.wr_cnt !== (CNT_EN ? 32'd6 : 32'd0)) begin
            n_fail++;
            $display("FAIL wr_cnt_after_burst: got %0d expected %0d", bus.wr_cnt, CNT_EN ? 6 : 0);
        end
    endtask

    task automatic test_read();
        logic [31:0] dat[3];
        logic [3:0]  be[3];
        logic [31:0] got_d[3];
        logic [3:0]  got_b[3];
        logic [6:0]  rdn_v, oen_v, vld_v;
        int          ptr, nv;
        logic        cap;
        dat[0] = 32'hA0; dat[1] = 32'hA1; dat[2] = 32'hA2;
        be[0]  = 4'hF;   be[1]  = 4'h3;   be[2]  = 4'h1;
        ptr = 0;
        nv  = 0;
        for (int c = 0; c < 7; c++) begin
            bus.rxf_n = (ptr < 3) ? 1'b0 : 1'b1;
            bus.idata = (ptr < 3) ? dat[ptr] : 32'h0;
            bus.ibe   = (ptr < 3) ? be[ptr] : 4'h0;
            #1;
            rdn_v[c] = bus.rd_n;
            oen_v[c] = bus.oe_n;
            vld_v[c] = bus.rx_vld;
            if (c == 1) begin
                n_tests++;
                if ({bus.dt_oe_n, bus.be_oe_n, bus.rd_n, bus.oe_n} !== 4'b1110) begin
                    n_fail++;
                    $display("FAIL rd_turnaround: dt_oe_n/be_oe_n/rd_n/oe_n %b expected 1110",
                             {bus.dt_oe_n, bus.be_oe_n, bus.rd_n, bus.oe_n});
                end
            end
            if (bus.rx_vld && nv < 3) begin
                got_d[nv] = bus.rx_dat;
                got_b[nv] = bus.rx_be;
                nv++;
            end
            cap = !bus.rd_n && !bus.rxf_n;
            step();
            if (cap) ptr++;
        end
        idle_inputs();
        n_tests++;
        if ({rdn_v, oen_v} !== {7'b1100011, 7'b1000001}) begin
            n_fail++;
            $display("FAIL rd_strobes: rd_n %b oe_n %b expected 1100011 1000001", rdn_v, oen_v);
        end
        n_tests++;
        if (vld_v !== 7'b0111000) begin
            n_fail++;
            $display("FAIL rd_vld_timing: rx_vld %b expected 0111000", vld_v);
        end
        n_tests++;
        if (nv != 3 || {got_d[0], got_d[1], got_d[2]} !== {32'hA0, 32'hA1, 32'hA2}
            || {got_b[0], got_b[1], got_b[2]} !== 12'hF31) begin
            n_fail++;
            $display("FAIL rd_data: count %0d data %h %h %h be %h %h %h expected 3 a0 a1 a2 f 3 1",
                     nv, got_d[0], got_d[1], got_d[2], got_b[0], got_b[1], got_b[2]);
        end
        step(); step();
    endtask

    task automatic test_arbitration();
        logic [19:0] rd_low, wr_low, oe_low;
        rst = 1'b1;
        bus.rxf_n  = 1'b0;
        bus.txe_n  = 1'b0;
        bus.tx_vld = 1'b1;
        bus.tx_dat = 32'h5A5A_0000;
        bus.idata  = 32'hC0DE_0000;
        bus.ibe    = 4'hF;
        step(); step();
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            rd_low[c] = !bus.rd_n;
            wr_low[c] = !bus.wr_n;
            oe_low[c] = !bus.oe_n;
            step();
        end
        idle_inputs();
        n_tests++;
        if (rd_low !== 20'h7803C) begin
            n_fail++;
            $display("FAIL arb_read_slots: rd_n low %h expected 7803c", rd_low);
        end
        n_tests++;
        if (wr_low !== 20'h00F00) begin
            n_fail++;
            $display("FAIL arb_write_slots: wr_n low %h expected 00f00", wr_low);
        end
        n_tests++;
        if (oe_low !== 20'h7C03E) begin
            n_fail++;
            $display("FAIL arb_oe_slots: oe_n low %h expected 7c03e", oe_low);
        end
        step(); step(); step();
    endtask

    task automatic test_rx_afull();
        logic [31:0] got[10];
        int          ptr, ng, af_cyc, extra, bad;
        logic        af_done, cap;
        ptr = 0; ng = 0; af_cyc = 0; extra = 0; af_done = 1'b0; bad = -1;
        bus.ibe = 4'hF;
        for (int c = 0; c < 80 && ng < 10; c++) begin
            bus.rxf_n = (ptr < 10) ? 1'b0 : 1'b1;
            bus.idata = 32'hD000_0000 + ptr;
            if (ptr >= 2 && !af_done) begin
                if (af_cyc < 6) begin
                    bus.rx_afull = 1'b1;
                    af_cyc++;
                end else begin
                    bus.rx_afull = 1'b0;
                    af_done = 1'b1;
                end
            end
            #1;
            if (bus.rx_afull && af_cyc == 1) begin
                n_tests++;
                if (bus.rd_n !== 1'b1) begin
                    n_fail++;
                    $display("FAIL afull_rd_n: got %b expected 1", bus.rd_n);
                end
            end
            if (bus.rx_afull && af_cyc == 6) begin
                n_tests++;
                if ({bus.rd_n, bus.oe_n} !== 2'b11) begin
                    n_fail++;
                    $display("FAIL afull_parked: rd_n/oe_n %b expected 11", {bus.rd_n, bus.oe_n});
                end
            end
            if (bus.rx_afull && bus.rx_vld) extra++;
            if (bus.rx_vld && ng < 10) begin
                got[ng] = bus.rx_dat;
                ng++;
            end
            cap = !bus.rd_n && !bus.rxf_n;
            step();
            if (cap) ptr++;
        end
        idle_inputs();
        n_tests++;
        if (extra > 1) begin
            n_fail++;
            $display("FAIL afull_extra_words: got %0d expected at most 1", extra);
        end
        for (int i = 0; i < ng; i++)
            if (bad < 0 && got[i] !== 32'hD000_0000 + i) bad = i;
        n_tests++;
        if (ng != 10 || bad >= 0) begin
            n_fail++;
            $display("FAIL afull_stream: words %0d first bad index %0d expected 10 words d0000000..d0000009, none bad",
                     ng, bad);
        end
        step(); step();
        n_tests++;
        if (bus.rd_cnt !== (CNT_EN ? 32'd18 : 32'd0)) begin
            n_fail++;
            $display("FAIL rd_cnt_total: got %0d expected %0d", bus.rd_cnt, CNT_EN ? 18 : 0);
        end
    endtask

    task automatic test_txe_stall();
        logic [31:0] got[8];
        int          k, ng, stall, bad;
        logic        xfer;
        k = 0; ng = 0; stall = 0; bad = -1;
        for (int c = 0; c < 60 && k < 5; c++) begin
            bus.tx_vld = 1'b1;
            bus.tx_dat = 32'h21 + k;
            bus.tx_be  = 4'hF;
            if (k >= 2 && stall < 4) begin
                bus.txe_n = 1'b1;
                stall++;
            end else begin
                bus.txe_n = 1'b0;
            end
            #1;
            if (bus.txe_n && stall == 1) begin
                n_tests++;
                if ({bus.tx_rdy, bus.wr_n} !== 2'b01) begin
                    n_fail++;
                    $display("FAIL txe_stall_rdy: tx_rdy/wr_n %b expected 01", {bus.tx_rdy, bus.wr_n});
                end
            end
            xfer = !bus.wr_n;
            if (xfer && ng < 8) begin
                got[ng] = bus.odata;
                ng++;
            end
            step();
            if (xfer) k++;
        end
        idle_inputs();
        for (int i = 0; i < ng && i < 5; i++)
            if (bad < 0 && got[i] !== 32'h21 + i) bad = i;
        n_tests++;
        if (ng != 5 || bad >= 0) begin
            n_fail++;
            $display("FAIL txe_stream: words %0d first bad index %0d expected 5 words 21..25, none bad", ng, bad);
        end
        step(); step(); step();
        n_tests++;
        if (bus.wr_cnt !== (CNT_EN ? 32'd9 : 32'd0)) begin
            n_fail++;
            $display("FAIL wr_cnt_total: got %0d expected %0d", bus.wr_cnt, CNT_EN ? 9 : 0);
        end
    endtask

    task automatic test_reset_mid_read();
        logic found;
        found = 1'b0;
        bus.rxf_n = 1'b0;
        bus.idata = 32'hBEEF_0001;
        bus.ibe   = 4'hF;
        for (int c = 0; c < 10 && !found; c++) begin
            #1;
            if (!bus.rd_n) found = 1'b1;
            else step();
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL rst_mid_wait: rd_n never went low within 10 cycles");
        end
        rst = 1'b1;
        step();
        #1;
        n_tests++;
        if ({bus.wr_n, bus.rd_n, bus.oe_n, bus.rx_vld} !== 4'b1110) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: wr_n/rd_n/oe_n/rx_vld %b expected 1110",
                     {bus.wr_n, bus.rd_n, bus.oe_n, bus.rx_vld});
        end
        n_tests++;
        if ({bus.wr_cnt, bus.rd_cnt} !== 64'd0) begin
            n_fail++;
            $display("FAIL rst_mid_counters: wr_cnt %0d rd_cnt %0d expected 0 0", bus.wr_cnt, bus.rd_cnt);
        end
        idle_inputs();
        rst = 1'b0;
        step(); step();
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read();
        test_arbitration();
        test_rx_afull();
        test_txe_stall();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
